// File: rtl/video_stream_framer.sv
// Frames a raw 32-bit word stream (two RGB565 pixels per word) into AXI4-Stream video.
// tuser marks start-of-frame and tlast marks end-of-line; geometry is latched at each frame start.
`timescale 1ns/1ps
module video_stream_framer #(
    parameter int WORDS_W = 12,
    parameter int LINES_W = 12
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               cfg_enable,
    input  logic [WORDS_W-1:0] cfg_hwords,
    input  logic [LINES_W-1:0] cfg_vlines,
    input  logic [31:0]        s_axis_raw_tdata,
    input  logic               s_axis_raw_tvalid,
    output logic               s_axis_raw_tready,
    output logic [31:0]        m_axis_vid_tdata,
    output logic               m_axis_vid_tvalid,
    input  logic               m_axis_vid_tready,
    output logic               m_axis_vid_tuser,
    output logic               m_axis_vid_tlast,
    output logic               stat_frame_done,
    output logic               stat_active
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic        user;
        logic        last;
    } beat_t;

    state_t             state;
    state_t             state_next;
    logic [WORDS_W-1:0] hwords;
    logic [WORDS_W-1:0] col;
    logic [LINES_W-1:0] vlines;
    logic [LINES_W-1:0] row;

    beat_t              in_beat;
    beat_t              out_beat;
    beat_t              out_beat_next;
    beat_t              skid_beat;
    beat_t              skid_beat_next;
    logic               out_valid;
    logic               out_valid_next;
    logic               skid_valid;
    logic               skid_valid_next;
    logic               in_ready;

    logic               push;
    logic               pop;
    logic               eol;
    logic               eof;
    logic               start;
    logic               done_next;
    logic               frame_done;
    logic               active;

    assign push  = s_axis_raw_tvalid && in_ready;
    assign pop   = out_valid && m_axis_vid_tready;
    assign eol   = (col == hwords - WORDS_W'(1));
    assign eof   = eol && (row == vlines - LINES_W'(1));
    assign start = cfg_enable && (cfg_hwords != '0) && (cfg_vlines != '0);

    // Tags are computed from the position counters at the moment a word is accepted.
    always_comb begin
        in_beat.data = s_axis_raw_tdata;
        in_beat.user = (col == '0) && (row == '0);
        in_beat.last = eol;
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (push && eof) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // The last word of the frame leaves when it pops with nothing behind it.
                if (pop && !skid_valid) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output register plus one-entry skid; the skid only fills when the output stalls.
    always_comb begin
        out_valid_next  = out_valid;
        out_beat_next   = out_beat;
        skid_valid_next = skid_valid;
        skid_beat_next  = skid_beat;
        if (pop) begin
            if (skid_valid) begin
                out_beat_next   = skid_beat;
                skid_valid_next = push;
                if (push) begin
                    skid_beat_next = in_beat;
                end
            end else begin
                out_valid_next = push;
                if (push) begin
                    out_beat_next = in_beat;
                end
            end
        end else if (push) begin
            if (out_valid) begin
                skid_valid_next = 1'b1;
                skid_beat_next  = in_beat;
            end else begin
                out_valid_next = 1'b1;
                out_beat_next  = in_beat;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            frame_done <= 1'b0;
            active     <= 1'b0;
        end else begin
            state      <= state_next;
            in_ready   <= (state_next == RUN) && !skid_valid_next;
            frame_done <= done_next;
            active     <= (state_next != IDLE) || done_next;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hwords <= '0;
            vlines <= '0;
            col    <= '0;
            row    <= '0;
        end else if ((state == IDLE) && start) begin
            hwords <= cfg_hwords;
            vlines <= cfg_vlines;
            col    <= '0;
            row    <= '0;
        end else if (push) begin
            if (eol) begin
                col <= '0;
                row <= row + LINES_W'(1);
            end else begin
                col <= col + WORDS_W'(1);
            end
        end
    end

    // NOTE: the payload registers are reset too, so tdata reads 0 straight out of reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid  <= 1'b0;
            out_beat   <= '0;
            skid_valid <= 1'b0;
            skid_beat  <= '0;
        end else begin
            out_valid  <= out_valid_next;
            out_beat   <= out_beat_next;
            skid_valid <= skid_valid_next;
            skid_beat  <= skid_beat_next;
        end
    end

    assign s_axis_raw_tready = in_ready;
    assign m_axis_vid_tvalid = out_valid;
    assign m_axis_vid_tdata  = out_beat.data;
    assign m_axis_vid_tuser  = out_beat.user;
    assign m_axis_vid_tlast  = out_beat.last;
    assign stat_frame_done   = frame_done;
    assign stat_active       = active;

endmodule

// File: tb/tb_video_stream_framer.sv
// Self-checking bench for video_stream_framer: a frame-position model predicts every output word
// and the frame_done pulse; directed scenarios pin the model with literal tag patterns.
`timescale 1ns/1ps
module tb_video_stream_framer;

    localparam int WORDS_W = 12;
    localparam int LINES_W = 12;

    logic               aclk = 1'b0;
    logic               aresetn = 1'b0;
    logic               cfg_enable;
    logic [WORDS_W-1:0] cfg_hwords;
    logic [LINES_W-1:0] cfg_vlines;
    logic [31:0]        s_tdata;
    logic               s_tvalid;
    logic               s_tready;
    logic [31:0]        m_tdata;
    logic               m_tvalid;
    logic               m_tready;
    logic               m_tuser;
    logic               m_tlast;
    logic               stat_frame_done;
    logic               stat_active;

    always #5 aclk = ~aclk;

    video_stream_framer #(.WORDS_W(WORDS_W), .LINES_W(LINES_W)) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .cfg_enable        (cfg_enable),
        .cfg_hwords        (cfg_hwords),
        .cfg_vlines        (cfg_vlines),
        .s_axis_raw_tdata  (s_tdata),
        .s_axis_raw_tvalid (s_tvalid),
        .s_axis_raw_tready (s_tready),
        .m_axis_vid_tdata  (m_tdata),
        .m_axis_vid_tvalid (m_tvalid),
        .m_axis_vid_tready (m_tready),
        .m_axis_vid_tuser  (m_tuser),
        .m_axis_vid_tlast  (m_tlast),
        .stat_frame_done   (stat_frame_done),
        .stat_active       (stat_active)
    );

    typedef struct {
        logic [31:0] data;
        bit          user;
        bit          last;
        bit          eof;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e_in;
    exp_t        e_out;
    int          checks = 0;
    int          errors = 0;
    int          frame_n = 0;
    int          cur_h = 0;
    int          cur_v = 0;
    bit          exp_done = 0;
    bit          stall_hold = 0;
    logic [33:0] held;
    int          cyc = 0;

    bit          obs_user[$];
    bit          obs_last[$];
    int          done_cnt = 0;
    bit          acc_seen = 0;
    int          first_acc_cyc = 0;
    int          first_pop_cyc = 0;
    int          last_pop_cyc = 0;
    int          ready_mode = 0;
    int          ready_phase = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_log();
        obs_user.delete();
        obs_last.delete();
        done_cnt = 0;
        acc_seen = 0;
    endtask

    function automatic logic [63:0] flags_vec(input bit sel_last);
        logic [63:0] v = '0;
        for (int i = 0; i < obs_user.size() && i < 64; i++) begin
            v[i] = sel_last ? obs_last[i] : obs_user[i];
        end
        return v;
    endfunction

    // Reference model and compare process, sampled on the falling edge.
    always @(negedge aclk) begin
        cyc++;
        if (!aresetn) begin
            exp_q.delete();
            frame_n    = 0;
            exp_done   = 0;
            stall_hold = 0;
        end else begin
            check("frame_done", stat_frame_done, exp_done);
            if (stat_frame_done) begin
                done_cnt++;
                check("active_at_done", stat_active, 1);
            end
            exp_done = 0;

            if (stall_hold) begin
                check("hold_valid", m_tvalid, 1);
                check("hold_beat", {m_tdata, m_tuser, m_tlast}, held);
            end

            if (m_tvalid && m_tready) begin
                check("active_on_pop", stat_active, 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_word", m_tdata, 64'hdead);
                end else begin
                    e_out = exp_q.pop_front();
                    check("tdata", m_tdata, e_out.data);
                    check("tuser", m_tuser, e_out.user);
                    check("tlast", m_tlast, e_out.last);
                    if (obs_user.size() == 0) first_pop_cyc = cyc;
                    last_pop_cyc = cyc;
                    obs_user.push_back(m_tuser);
                    obs_last.push_back(m_tlast);
                    if (e_out.eof) exp_done = 1;
                end
            end
            stall_hold = m_tvalid && !m_tready;
            held       = {m_tdata, m_tuser, m_tlast};

            if (s_tvalid && s_tready) begin
                if (frame_n == 0) begin
                    cur_h = int'(cfg_hwords);
                    cur_v = int'(cfg_vlines);
                end
                e_in.data = s_tdata;
                e_in.user = (frame_n == 0);
                e_in.last = (cur_h != 0) && ((frame_n % cur_h) == cur_h - 1);
                e_in.eof  = (frame_n == cur_h * cur_v - 1);
                frame_n   = e_in.eof ? 0 : frame_n + 1;
                exp_q.push_back(e_in);
                if (!acc_seen) begin
                    acc_seen      = 1;
                    first_acc_cyc = cyc;
                end
            end
        end
    end

    // Downstream ready: 0 = always ready, 1 = 1,0,0,1 pattern, other = random.
    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            case (ready_mode)
                0: m_tready = 1'b1;
                1: begin
                    m_tready    = (ready_phase == 0) || (ready_phase == 3);
                    ready_phase = (ready_phase + 1) % 4;
                end
                default: m_tready = ($urandom_range(1) == 1);
            endcase
        end
    end

    task automatic send_words(input int count, input int vpct);
        int sent = 0;
        int guard = 0;
        bit acc;
        while (sent < count) begin
            if (!s_tvalid && ($urandom_range(99) < vpct)) begin
                s_tvalid = 1'b1;
                s_tdata  = $urandom;
            end
            @(negedge aclk);
            acc = s_tvalid && s_tready;
            @(posedge aclk);
            #1;
            if (acc) begin
                sent++;
                s_tvalid = 1'b0;
                guard    = 0;
            end else if (++guard > 500) begin
                check("send_timeout", sent, count);
                break;
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        bit quiet = 0;
        while (!quiet && n < 1000) begin
            @(negedge aclk);
            n++;
            quiet = (exp_q.size() == 0) && !stat_active && !m_tvalid;
        end
        check("drain_timeout", quiet, 1);
        @(posedge aclk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_tready"}, s_tready, 0);
        check({tag, "_m_tvalid"}, m_tvalid, 0);
        check({tag, "_m_tdata"}, m_tdata, 0);
        check({tag, "_m_tuser"}, m_tuser, 0);
        check({tag, "_m_tlast"}, m_tlast, 0);
        check({tag, "_frame_done"}, stat_frame_done, 0);
        check({tag, "_active"}, stat_active, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        cfg_enable = 1'b0;
        cfg_hwords = WORDS_W'(4);
        cfg_vlines = LINES_W'(3);
        s_tvalid   = 1'b0;
        s_tdata    = '0;
        #1;
        check_all_zero("reset");
        #20;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // 4x3 frame, continuous valid and ready.
        clear_log();
        ready_mode = 0;
        cfg_enable = 1'b1;
        send_words(1, 100);
        cfg_enable = 1'b0;
        send_words(11, 100);
        wait_idle();
        check("t1_words", obs_user.size(), 12);
        check("t1_tuser", flags_vec(0), 64'h001);
        check("t1_tlast", flags_vec(1), 64'h888);
        check("t1_done", done_cnt, 1);
        check("t1_latency", first_pop_cyc - first_acc_cyc, 1);
        check("t1_rate", last_pop_cyc - first_pop_cyc, 11);

        // 4x3 frame, ready toggling 1,0,0,1 and random valid.
        clear_log();
        ready_mode  = 1;
        ready_phase = 0;
        cfg_enable  = 1'b1;
        send_words(1, 60);
        cfg_enable = 1'b0;
        send_words(11, 60);
        wait_idle();
        check("t2_words", obs_user.size(), 12);
        check("t2_tuser", flags_vec(0), 64'h001);
        check("t2_tlast", flags_vec(1), 64'h888);
        check("t2_done", done_cnt, 1);

        // One word per line, two lines.
        clear_log();
        ready_mode = 0;
        cfg_hwords = WORDS_W'(1);
        cfg_vlines = LINES_W'(2);
        cfg_enable = 1'b1;
        send_words(1, 100);
        cfg_enable = 1'b0;
        send_words(1, 100);
        wait_idle();
        check("t3_tuser", flags_vec(0), 64'h1);
        check("t3_tlast", flags_vec(1), 64'h3);
        check("t3_done", done_cnt, 1);

        // Line length changed mid-frame applies only to the following frame.
        clear_log();
        cfg_hwords = WORDS_W'(4);
        cfg_vlines = LINES_W'(3);
        cfg_enable = 1'b1;
        send_words(2, 100);
        cfg_hwords = WORDS_W'(8);
        send_words(11, 100);
        cfg_enable = 1'b0;
        send_words(23, 100);
        wait_idle();
        check("t4_words", obs_user.size(), 36);
        check("t4_done", done_cnt, 2);
        check("t4_last_w11", obs_last[11], 1);
        check("t4_sof_w12", obs_user[12], 1);
        check("t4_last_w15", obs_last[15], 0);
        check("t4_last_w19", obs_last[19], 1);

        // Zero geometry never starts a frame.
        cfg_hwords = '0;
        cfg_vlines = LINES_W'(3);
        cfg_enable = 1'b1;
        s_tvalid   = 1'b1;
        s_tdata    = $urandom;
        bad = 0;
        repeat (100) begin
            @(negedge aclk);
            if (s_tready || m_tvalid || stat_active) bad++;
        end
        check("t5_zero_hwords", bad, 0);
        @(posedge aclk);
        #1;
        cfg_hwords = WORDS_W'(4);
        cfg_vlines = '0;
        bad = 0;
        repeat (20) begin
            @(negedge aclk);
            if (s_tready || m_tvalid || stat_active) bad++;
        end
        check("t5_zero_vlines", bad, 0);
        @(posedge aclk);
        #1;
        s_tvalid   = 1'b0;
        cfg_enable = 1'b0;
        cfg_vlines = LINES_W'(3);
        @(posedge aclk);
        #1;

        // Reset in the middle of a frame, then a clean restart.
        cfg_enable = 1'b1;
        send_words(5, 100);
        aresetn = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        clear_log();
        ready_mode = 2;
        send_words(1, 70);
        cfg_enable = 1'b0;
        send_words(11, 70);
        wait_idle();
        check("t6_tuser", flags_vec(0), 64'h001);
        check("t6_tlast", flags_vec(1), 64'h888);
        check("t6_done", done_cnt, 1);

        // Random geometry, random handshakes, cfg scribbled while a frame is in flight.
        for (int it = 0; it < 6; it++) begin
            int h;
            int v;
            int vpct;
            h    = $urandom_range(1, 5);
            v    = $urandom_range(1, 3);
            vpct = $urandom_range(30, 100);
            clear_log();
            ready_mode = 2;
            cfg_hwords = WORDS_W'(h);
            cfg_vlines = LINES_W'(v);
            cfg_enable = 1'b1;
            send_words(1, vpct);
            cfg_enable = 1'b0;
            cfg_hwords = WORDS_W'($urandom_range(1, 7));
            cfg_vlines = LINES_W'($urandom_range(1, 4));
            send_words(h * v - 1, vpct);
            wait_idle();
            check("rand_words", obs_user.size(), h * v);
            check("rand_done", done_cnt, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
